// File: rtl/int_request_unit.sv
// Interrupt initiator: synchronises /INT and /NMI, applies IFF1/IFF2 and EI-shadow rules,
// raises interrupt_RQ to the flush unit, and hands a service record to the sequencer.
module int_request_unit #(
  parameter logic [15:0] IM1_VECTOR = 16'h0038,
  parameter logic [15:0] NMI_VECTOR = 16'h0066
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        int_n,
  input  logic        nmi_n,
  input  logic        instr_commit,
  input  logic        ei_commit,
  input  logic        di_commit,
  input  logic        retn_commit,
  input  logic        PCupdate,
  input  logic        br_taken,
  input  logic        paging_RQ,
  input  logic        mem_pipe_stall,
  input  logic [15:0] targetPC,
  input  logic        svc_done,
  output logic        interrupt_RQ,
  output logic        int_service,
  output logic        int_is_nmi,
  output logic [15:0] int_vector,
  output logic [15:0] int_return_PC,
  output logic        int_ack,
  output logic        IFF1,
  output logic        IFF2
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ_INT   = 3'd1,
    REQ_NMI   = 3'd2,
    SERVICE   = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  state_t state, next_state;

  logic int_meta, int_s;
  logic nmi_meta, nmi_s, nmi_s_d;
  logic nmi_fall;
  logic nmi_latch;
  logic ei_shadow;
  logic int_ok;
  logic accept;
  logic accept_nmi;

  // Synchronisers idle high so reset never looks like an asserted line or an NMI edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      int_meta <= 1'b1;
      int_s    <= 1'b1;
      nmi_meta <= 1'b1;
      nmi_s    <= 1'b1;
      nmi_s_d  <= 1'b1;
    end else begin
      int_meta <= int_n;
      int_s    <= int_meta;
      nmi_meta <= nmi_n;
      nmi_s    <= nmi_meta;
      nmi_s_d  <= nmi_s;
    end
  end

  assign nmi_fall   = nmi_s_d & ~nmi_s;
  assign int_ok     = ~int_s & IFF1 & ~ei_shadow;
  assign accept     = interrupt_RQ & PCupdate & ~br_taken & ~paging_RQ & ~mem_pipe_stall;
  assign accept_nmi = accept & (state == REQ_NMI);

  // A new edge outranks the clear, so an NMI arriving during its predecessor's accept survives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           nmi_latch <= 1'b0;
    else if (nmi_fall)   nmi_latch <= 1'b1;
    else if (accept_nmi) nmi_latch <= 1'b0;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (nmi_latch)   next_state = REQ_NMI;
        else if (int_ok) next_state = REQ_INT;
      end
      REQ_INT: begin
        if (accept)         next_state = SERVICE;
        else if (nmi_latch) next_state = REQ_NMI;
        else if (!int_ok)   next_state = IDLE;
      end
      REQ_NMI: begin
        if (accept) next_state = SERVICE;
      end
      SERVICE:   next_state = WAIT_DONE;
      WAIT_DONE: begin
        if (svc_done) next_state = IDLE;
      end
      default:   next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      interrupt_RQ  <= 1'b0;
      int_service   <= 1'b0;
      int_ack       <= 1'b0;
      int_is_nmi    <= 1'b0;
      int_vector    <= 16'h0000;
      int_return_PC <= 16'h0000;
    end else begin
      state        <= next_state;
      interrupt_RQ <= (next_state == REQ_INT) || (next_state == REQ_NMI);
      int_service  <= accept;
      int_ack      <= accept & (state == REQ_INT);
      // Service record is captured at accept and held until the next one.
      if (accept) begin
        int_is_nmi    <= accept_nmi;
        int_vector    <= accept_nmi ? NMI_VECTOR : IM1_VECTOR;
        int_return_PC <= targetPC;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      IFF1 <= 1'b0;
      IFF2 <= 1'b0;
    end else if (accept_nmi) begin
      IFF2 <= IFF1;
      IFF1 <= 1'b0;
    end else if (accept) begin
      IFF1 <= 1'b0;
      IFF2 <= 1'b0;
    end else if (instr_commit && di_commit) begin
      IFF1 <= 1'b0;
      IFF2 <= 1'b0;
    end else if (instr_commit && ei_commit) begin
      IFF1 <= 1'b1;
      IFF2 <= 1'b1;
    end else if (instr_commit && retn_commit) begin
      IFF1 <= IFF2;
    end
  end

  // The shadow covers the instruction after EI; consecutive EIs keep re-arming it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          ei_shadow <= 1'b0;
    else if (instr_commit && di_commit) ei_shadow <= 1'b0;
    else if (instr_commit && ei_commit) ei_shadow <= 1'b1;
    else if (instr_commit)              ei_shadow <= 1'b0;
  end

endmodule
